// File: rtl/mmio_pkg.sv
// Shared encodings for the MMIO interconnect: FSM states, access sizes,
// error causes and the alignment rule used at decode time.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mmio_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // An access is rejected when its width does not fit the low address
    // bits; the reserved size code is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mmio_read_aligner.sv
// Picks the addressed byte or half out of a device read word and extends it
// to 32 bits; word reads pass through untouched.
module mmio_read_aligner
    import mmio_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zext,
    output logic [31:0] word_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // lane extraction followed by sign or zero extension
    always_comb begin
        byte_sel = word_in[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? word_in[31:16] : word_in[15:0];
        case (size)
            SZ_BYTE: word_out = {{24{~zext & byte_sel[7]}}, byte_sel};
            SZ_HALF: word_out = {{16{~zext & half_sel[15]}}, half_sel};
            default: word_out = word_in;
        endcase
    end

endmodule

// File: rtl/mmio_interconnect.sv
// Memory-mapped interconnect between the core data port and N_DEV device
// slots. Decodes base/mask windows (lowest slot wins), rejects misaligned
// and unmapped accesses at decode, waits on the selected device's ready
// with a timeout, and returns windowed read data with a one-cycle pulse.
module mmio_interconnect
    import mmio_pkg::*;
#(
    parameter int                      N_DEV   = 6,
    parameter int                      ADDR_W  = 32,
    parameter logic [N_DEV*ADDR_W-1:0] BASE    = '0,
    parameter logic [N_DEV*ADDR_W-1:0] MASK    = '0,
    parameter int                      TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [31:0]         cpu_wdata,
    input  logic [1:0]          cpu_size,
    input  logic                cpu_zext,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_ready,
    output logic                cpu_err,
    output logic [1:0]          err_cause,
    output logic [N_DEV-1:0]    dev_sel,
    output logic [ADDR_W-1:0]   dev_addr,
    output logic                dev_we,
    output logic [1:0]          dev_size,
    output logic [31:0]         dev_wdata,
    input  logic [N_DEV*32-1:0] dev_rdata,
    input  logic [N_DEV-1:0]    dev_ready
);

    localparam int         IDX_W     = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_WAIT    = ST_WAIT;
    localparam logic [1:0] S_RESP    = ST_RESP;
    // Down-counter load: terminal count 0 is reached on the TIMEOUT-th WAIT cycle.
    localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx_q;
    logic              zext_q;
    logic [1:0]        lane_q;
    logic [7:0]        wait_cnt;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic [ADDR_W-1:0] dec_local;
    logic              dec_misalign;
    logic              accept;

    logic [31:0]       sel_rdata;
    logic              sel_ready;
    logic [31:0]       aligned;

    // window decode; scanning downwards lets the lowest matching slot win
    always_comb begin
        dec_hit   = 1'b0;
        dec_idx   = '0;
        dec_local = cpu_addr;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if ((cpu_addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
                dec_hit   = 1'b1;
                dec_idx   = IDX_W'(i);
                dec_local = cpu_addr & ~MASK[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign dec_misalign = is_misaligned(cpu_size, cpu_addr[1:0]);
    assign accept       = (state == S_IDLE) && cpu_req && !dec_misalign && dec_hit;
    assign sel_rdata    = dev_rdata[idx_q*32 +: 32];
    assign sel_ready    = dev_ready[idx_q];

    mmio_read_aligner u_aligner (
        .word_in  (sel_rdata),
        .addr_lo  (lane_q),
        .size     (dev_size),
        .zext     (zext_q),
        .word_out (aligned)
    );

    // device select follows the registered state so reset drops it at once
    always_comb begin
        dev_sel = '0;
        if (state == S_WAIT) begin
            dev_sel[idx_q] = 1'b1;
        end
    end

    // request latch: only accepted accesses reach the device bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            dev_addr  <= '0;
            dev_we    <= 1'b0;
            dev_size  <= '0;
            dev_wdata <= '0;
            zext_q    <= 1'b0;
            lane_q    <= '0;
        end else if (accept) begin
            idx_q     <= dec_idx;
            dev_addr  <= dec_local;
            dev_we    <= cpu_we;
            dev_size  <= cpu_size;
            dev_wdata <= cpu_wdata;
            zext_q    <= cpu_zext;
            lane_q    <= cpu_addr[1:0];
        end
    end

    // access FSM with registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            err_cause <= ERR_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        if (dec_misalign) begin
                            state     <= S_RESP;
                            cpu_ready <= 1'b1;
                            cpu_err   <= 1'b1;
                            cpu_rdata <= '0;
                            err_cause <= ERR_MISALIGN;
                        end else if (!dec_hit) begin
                            state     <= S_RESP;
                            cpu_ready <= 1'b1;
                            cpu_err   <= 1'b1;
                            cpu_rdata <= '0;
                            err_cause <= ERR_UNMAPPED;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (sel_ready) begin
                        state     <= S_RESP;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b0;
                        cpu_rdata <= dev_we ? '0 : aligned;
                    end else if (wait_cnt == '0) begin
                        state     <= S_RESP;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        cpu_rdata <= '0;
                        err_cause <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    cpu_rdata <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Bench for mmio_interconnect: directed accesses against a slot model with
// per-slot latencies, a per-cycle compare process and literal spot checks.
module tb_mmio_interconnect;

    localparam int N  = 6;
    localparam int AW = 32;
    localparam int TO = 15;

    // slot 5 .. slot 0
    localparam logic [N*AW-1:0] BASE_P = {32'h0002_0000, 32'h0001_0000, 32'h0000_4000,
                                          32'h0001_0000, 32'h0000_3000, 32'h0000_2000};
    localparam logic [N*AW-1:0] MASK_P = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000,
                                          32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000};
    localparam logic [N-1:0]    NOISE  = 6'b100010;

    logic           clk, rst, cpu_req, cpu_we, cpu_zext;
    logic [AW-1:0]  cpu_addr;
    logic [31:0]    cpu_wdata;
    logic [1:0]     cpu_size;
    logic [31:0]    cpu_rdata;
    logic           cpu_ready, cpu_err;
    logic [1:0]     err_cause;
    logic [N-1:0]   dev_sel;
    logic [AW-1:0]  dev_addr;
    logic           dev_we;
    logic [1:0]     dev_size;
    logic [31:0]    dev_wdata;
    logic [N*32-1:0] dev_rdata;
    logic [N-1:0]   dev_ready;

    // slot map, slot 0 first; 255 latency = never ready
    logic [31:0] m_base [N] = '{32'h2000, 32'h3000, 32'h10000, 32'h4000, 32'h10000, 32'h20000};
    logic [31:0] m_mask [N] = '{32'hFFFFF000, 32'hFFFFF000, 32'hFFFF0000,
                                32'hFFFFF000, 32'hFFFFF000, 32'hFFFF0000};
    int          lat    [N] = '{0, 5, 1, 255, 0, 14};

    int total = 0;
    int bad   = 0;
    int edges = 0;
    int scnt  = 0;

    logic        m_active = 1'b0;
    int          m_t0 = 0, m_idx = 0, m_nsel = 0, m_done_k = 0;
    logic        m_err = 1'b0;
    logic [1:0]  m_new_cause = 2'd0, m_cause_prev = 2'd0;
    logic [31:0] m_rdata = '0, m_daddr = '0, m_wdata = '0;
    logic        m_we = 1'b0;
    logic [1:0]  m_size = 2'd0;

    int          mk;
    logic        exp_ready;
    logic [N-1:0] exp_sel;
    logic [1:0]  exp_cause;

    int          obs_ready_cnt = 0, obs_sel_cnt = 0, obs_k = 0;
    logic [31:0] obs_rdata = '0, obs_daddr = '0, obs_dwdata = '0;
    logic        obs_err = 1'b0, obs_dwe = 1'b0;
    logic [N-1:0] obs_sel = '0;

    mmio_interconnect #(
        .N_DEV(N), .ADDR_W(AW), .BASE(BASE_P), .MASK(MASK_P), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_zext(cpu_zext),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .err_cause(err_cause), .dev_sel(dev_sel), .dev_addr(dev_addr), .dev_we(dev_we),
        .dev_size(dev_size), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
        .dev_ready(dev_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edges <= edges + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] w, input logic [1:0] a,
                                               input logic [1:0] sz, input logic zx);
        longint v;
        if (sz == 2'd0) begin
            v = (w >> (8 * a)) % 256;
            if (!zx && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * a[1])) % 65536;
            if (!zx && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return 32'(v);
    endfunction

    // device responders: ready after lat cycles of select; some idle slots
    // keep ready asserted to show it is ignored
    initial begin
        dev_ready = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dev_sel != '0) scnt++;
            else scnt = 0;
            for (int i = 0; i < N; i++)
                dev_ready[i] = dev_sel[i] ? (scnt > lat[i]) : NOISE[i];
        end
    end

    // per-cycle compare against the transaction model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mk        = edges - m_t0;
                exp_ready = m_active && (mk == m_done_k);
                exp_sel   = '0;
                if (m_active && mk >= 1 && mk <= m_nsel) exp_sel[m_idx] = 1'b1;
                exp_cause = (m_active && m_err && mk >= m_done_k) ? m_new_cause : m_cause_prev;
                chk("cpu_ready", 32'(cpu_ready), 32'(exp_ready));
                chk("dev_sel", 32'(dev_sel), 32'(exp_sel));
                chk("err_cause", 32'(err_cause), 32'(exp_cause));
                if (exp_ready) begin
                    chk("cpu_err", 32'(cpu_err), 32'(m_err));
                    chk("cpu_rdata", cpu_rdata, m_rdata);
                end
                if (exp_sel != '0) begin
                    chk("dev_addr", dev_addr, m_daddr);
                    chk("dev_we", 32'(dev_we), 32'(m_we));
                    chk("dev_size", 32'(dev_size), 32'(m_size));
                    chk("dev_wdata", dev_wdata, m_wdata);
                end
                if (cpu_ready) begin
                    obs_ready_cnt++;
                    obs_rdata = cpu_rdata;
                    obs_err   = cpu_err;
                    obs_k     = mk;
                end
                if (dev_sel != '0) begin
                    obs_sel_cnt++;
                    obs_sel    = dev_sel;
                    obs_daddr  = dev_addr;
                    obs_dwe    = dev_we;
                    obs_dwdata = dev_wdata;
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic zx, input logic [31:0] wdata);
        int   hit;
        logic mis;
        hit = -1;
        for (int i = 0; i < N; i++)
            if (hit < 0 && (addr & m_mask[i]) == m_base[i]) hit = i;
        mis = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'd0);
        @(posedge clk);
        #2;
        m_err = 1'b0; m_new_cause = 2'd0; m_nsel = 0; m_rdata = '0; m_idx = 0;
        if (mis) begin
            m_err = 1'b1; m_new_cause = 2'd2;
        end else if (hit < 0) begin
            m_err = 1'b1; m_new_cause = 2'd1;
        end else begin
            m_idx   = hit;
            m_daddr = addr & ~m_mask[hit];
            m_we    = we;
            m_size  = size;
            m_wdata = wdata;
            if (lat[hit] + 1 <= TO) begin
                m_nsel = lat[hit] + 1;
                if (!we) m_rdata = model_read(dev_rdata[hit*32 +: 32], addr[1:0], size, zx);
            end else begin
                m_nsel = TO; m_err = 1'b1; m_new_cause = 2'd3;
            end
        end
        m_done_k = m_nsel + 1;
        obs_ready_cnt = 0; obs_sel_cnt = 0; obs_k = 0; obs_rdata = 'x; obs_err = 1'bx;
        obs_sel = '0; obs_dwe = 1'bx; obs_dwdata = 'x; obs_daddr = 'x;
        m_t0 = edges;
        m_active = 1'b1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_size = size;
        cpu_zext = zx; cpu_wdata = wdata;
        @(posedge clk);
        #2;
        cpu_req = 1'b0; cpu_we = ~we; cpu_addr = ~addr; cpu_size = ~size;
        cpu_zext = ~zx; cpu_wdata = ~wdata;
    endtask

    task automatic wait_done();
        while (edges < m_t0 + m_done_k + 1) begin
            @(posedge clk);
            #1;
        end
        #1;
        if (m_err) m_cause_prev = m_new_cause;
        m_active = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(cpu_ready), 32'd0);
        chk({tag, "_err"}, 32'(cpu_err), 32'd0);
        chk({tag, "_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_cause"}, 32'(err_cause), 32'd0);
        chk({tag, "_sel"}, 32'(dev_sel), 32'd0);
        chk({tag, "_daddr"}, dev_addr, 32'd0);
        chk({tag, "_dwe"}, 32'(dev_we), 32'd0);
        chk({tag, "_dsize"}, 32'(dev_size), 32'd0);
        chk({tag, "_dwdata"}, dev_wdata, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_size = 2'd0; cpu_zext = 1'b0;
        dev_rdata[0*32 +: 32] = 32'h1234_5678;
        dev_rdata[1*32 +: 32] = 32'h0BAD_BEEF;
        dev_rdata[2*32 +: 32] = 32'h2222_2222;
        dev_rdata[3*32 +: 32] = 32'h3333_3333;
        dev_rdata[4*32 +: 32] = 32'h4444_4444;
        dev_rdata[5*32 +: 32] = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        rst = 1'b0;

        issue(1'b0, 32'h2004, 2'd2, 1'b0, 32'h0);
        wait_done();
        chk("lit_word_rdata", obs_rdata, 32'h1234_5678);
        chk("lit_word_err", 32'(obs_err), 32'd0);
        chk("lit_word_lat", 32'(obs_k), 32'd2);
        chk("lit_word_daddr", obs_daddr, 32'h0000_0004);

        dev_rdata[0*32 +: 32] = 32'h80FF_FFFF;
        issue(1'b0, 32'h2003, 2'd0, 1'b0, 32'h0);
        wait_done();
        chk("lit_byte_sext", obs_rdata, 32'hFFFF_FF80);
        issue(1'b0, 32'h2003, 2'd0, 1'b1, 32'h0);
        wait_done();
        chk("lit_byte_zext", obs_rdata, 32'h0000_0080);
        issue(1'b0, 32'h2002, 2'd1, 1'b0, 32'h0);
        wait_done();
        chk("lit_half_sext", obs_rdata, 32'hFFFF_80FF);

        issue(1'b0, 32'h3008, 2'd2, 1'b0, 32'h0);
        wait_done();
        chk("lit_slow_sel", 32'(obs_sel_cnt), 32'd6);
        chk("lit_slow_pulses", 32'(obs_ready_cnt), 32'd1);
        chk("lit_slow_rdata", obs_rdata, 32'h0BAD_BEEF);

        issue(1'b0, 32'h4000, 2'd2, 1'b0, 32'h0);
        wait_done();
        chk("lit_to_sel", 32'(obs_sel_cnt), 32'd15);
        chk("lit_to_err", 32'(obs_err), 32'd1);
        chk("lit_to_cause", 32'(err_cause), 32'd3);
        chk("lit_to_lat", 32'(obs_k), 32'd16);

        issue(1'b0, 32'h20000, 2'd2, 1'b0, 32'h0);
        wait_done();
        chk("lit_edge_sel", 32'(obs_sel_cnt), 32'd15);
        chk("lit_edge_err", 32'(obs_err), 32'd0);
        chk("lit_edge_rdata", obs_rdata, 32'hCAFE_F00D);
        chk("lit_edge_cause_held", 32'(err_cause), 32'd3);

        issue(1'b0, 32'h2001, 2'd1, 1'b0, 32'h0);
        wait_done();
        chk("lit_mis_cause", 32'(err_cause), 32'd2);
        chk("lit_mis_sel", 32'(obs_sel_cnt), 32'd0);

        issue(1'b0, 32'hF000_0000, 2'd2, 1'b0, 32'h0);
        wait_done();
        chk("lit_unmap_cause", 32'(err_cause), 32'd1);
        chk("lit_unmap_lat", 32'(obs_k), 32'd1);
        chk("lit_unmap_err", 32'(obs_err), 32'd1);
        chk("lit_unmap_sel", 32'(obs_sel_cnt), 32'd0);

        issue(1'b0, 32'hF000_0002, 2'd2, 1'b0, 32'h0);
        wait_done();
        chk("lit_mis_over_unmap", 32'(err_cause), 32'd2);
        issue(1'b0, 32'hF000_0000, 2'd0, 1'b0, 32'h0);
        wait_done();
        issue(1'b0, 32'h2000, 2'd3, 1'b0, 32'h0);
        wait_done();
        chk("lit_rsvd_size", 32'(err_cause), 32'd2);

        issue(1'b0, 32'h10010, 2'd2, 1'b0, 32'h0);
        wait_done();
        chk("lit_overlap_sel", 32'(obs_sel), 32'b000100);
        chk("lit_overlap_rdata", obs_rdata, 32'h2222_2222);

        issue(1'b1, 32'h2001, 2'd0, 1'b0, 32'h0000_00A5);
        wait_done();
        chk("lit_wr_we", 32'(obs_dwe), 32'd1);
        chk("lit_wr_wdata", obs_dwdata, 32'h0000_00A5);
        chk("lit_wr_rdata", obs_rdata, 32'd0);

        issue(1'b0, 32'h3008, 2'd2, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        m_active = 1'b0;
        m_cause_prev = 2'd0;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_wait");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        obs_ready_cnt = 0;
        repeat (4) @(posedge clk);
        #2;
        chk("lit_rst_no_ready", 32'(obs_ready_cnt), 32'd0);
        issue(1'b0, 32'h2004, 2'd2, 1'b0, 32'h0);
        wait_done();
        chk("lit_after_rst_rdata", obs_rdata, 32'h80FF_FFFF);
        chk("lit_after_rst_pulses", 32'(obs_ready_cnt), 32'd1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
